mips_mem_arbiter: RTL and testbench

- Shares one off-processor memory port between two requesters: the MIPS processor (port P) and a DMA/program loader (port D).
- Sits between the processor's memory interface (read/write strobes, address, write data) and external memory.
- Memory latency is variable and signalled by mem_ready.
- Provides round-robin arbitration, per-transaction grant locking, a wait signal used to stall the processor, and a watchdog abort on a hung memory.

---
 rtl/mips_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// Two-port memory arbiter: MIPS processor (P) and DMA/loader (D) share one memory port.
// Round-robin on ties, grant locked for the whole transaction, watchdog abort on a hung memory.
module mips_mem_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_rd,
  input  logic              p_wr,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_ack,
  output logic              p_err,
  output logic              p_wait,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic              d_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Counter value on the last BUSY cycle the watchdog allows
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;
  logic              p_act;
  logic              d_act;
  logic              grant_en;
  logic              grant_sel;
  logic              done_ok;
  logic              abort;
  logic              owner_q;
  logic              last_grant;
  logic              dir_wr;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] p_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic [DATA_W-1:0] cap_data;
  logic [TO_W-1:0]   cnt;

  assign p_act = p_rd | p_wr;
  assign d_act = d_rd | d_wr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    grant_sel = 1'b0;
    done_ok   = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (p_act || d_act) begin
          grant_en  = 1'b1;
          grant_sel = (p_act && d_act) ? ~last_grant : d_act;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // mem_ready takes priority over a watchdog expiry in the same cycle
        if (mem_ready) begin
          done_ok   = 1'b1;
          state_nxt = ACK;
        end else if (cnt == TO_LAST) begin
          abort     = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cap_data = (done_ok && !dir_wr) ? mem_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q    <= 1'b0;
      last_grant <= 1'b1;
      dir_wr     <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      p_rdata_q  <= '0;
      d_rdata_q  <= '0;
      cnt        <= '0;
    end else begin
      if (grant_en) begin
        owner_q    <= grant_sel;
        last_grant <= grant_sel;
        addr_q     <= grant_sel ? d_addr  : p_addr;
        wdata_q    <= grant_sel ? d_wdata : p_wdata;
        dir_wr     <= grant_sel ? d_wr    : p_wr;
        err_q      <= 1'b0;
        cnt        <= '0;
      end
      if (state == BUSY) cnt <= cnt + TO_W'(1);
      if (done_ok || abort) begin
        if (owner_q) d_rdata_q <= cap_data;
        else         p_rdata_q <= cap_data;
        err_q <= abort;
      end
      if (state == ACK) cnt <= '0;
    end
  end

  assign busy      = (state != IDLE);
  assign owner     = owner_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = (state == BUSY) & ~dir_wr;
  assign mem_write = (state == BUSY) & dir_wr;
  assign p_ack     = (state == ACK) & ~owner_q;
  assign d_ack     = (state == ACK) & owner_q;
  assign p_err     = p_ack & err_q;
  assign d_err     = d_ack & err_q;
  assign p_rdata   = p_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign p_wait    = p_act & ~p_ack;
  assign d_wait    = d_act & ~d_ack;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mips_mem_arbiter;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              p_rd, p_wr, d_rd, d_wr;
  logic [ADDR_W-1:0] p_addr, d_addr, mem_addr;
  logic [DATA_W-1:0] p_wdata, d_wdata, p_rdata, d_rdata, mem_wdata, mem_rdata;
  logic              p_ack, p_err, p_wait, d_ack, d_err, d_wait;
  logic              mem_read, mem_write, mem_ready, busy, owner;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mips_mem_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk(clk), .reset(reset),
    .p_rd(p_rd), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_ack(p_ack), .p_err(p_err), .p_wait(p_wait),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err), .d_wait(d_wait),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .owner(owner)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction model: one in-flight transaction, a busy-cycle age, a one-cycle
  // completion phase, and a tie-break preference that flips after every grant.
  bit                m_active = 0;
  bit                m_in_ack = 0;
  bit                m_err = 0;
  bit                m_owner = 0;
  bit                m_wr = 0;
  bit                m_prefer_d = 0;
  int                m_age = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic [DATA_W-1:0] m_rdata [2] = '{default: '0};
  int                grant_log [$];

  always @(posedge clk or posedge reset) begin : model
    bit pa, da, who;
    int age;
    if (reset) begin
      m_active   <= 0;
      m_in_ack   <= 0;
      m_err      <= 0;
      m_owner    <= 0;
      m_wr       <= 0;
      m_prefer_d <= 0;
      m_age      <= 0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_rdata[0] <= '0;
      m_rdata[1] <= '0;
    end else if (m_in_ack) begin
      m_in_ack <= 0;
    end else if (m_active) begin
      age = m_age + 1;
      m_age <= age;
      if (mem_ready || age == TIMEOUT) begin
        m_err            <= !mem_ready;
        m_rdata[m_owner] <= (mem_ready && !m_wr) ? mem_rdata : '0;
        m_active         <= 0;
        m_in_ack         <= 1;
      end
    end else begin
      pa = p_rd | p_wr;
      da = d_rd | d_wr;
      if (pa || da) begin
        who = (pa && da) ? m_prefer_d : da;
        grant_log.push_back(int'(who));
        m_owner    <= who;
        m_prefer_d <= !who;
        m_addr     <= who ? d_addr : p_addr;
        m_wdata    <= who ? d_wdata : p_wdata;
        m_wr       <= who ? d_wr : p_wr;
        m_active   <= 1;
        m_age      <= 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic ep_ack, ed_ack;
    ep_ack = m_in_ack && !m_owner;
    ed_ack = m_in_ack && m_owner;
    checkOutput("p_ack", p_ack, ep_ack);
    checkOutput("d_ack", d_ack, ed_ack);
    checkOutput("p_err", p_err, ep_ack && m_err);
    checkOutput("d_err", d_err, ed_ack && m_err);
    checkOutput("p_rdata", p_rdata, m_rdata[0]);
    checkOutput("d_rdata", d_rdata, m_rdata[1]);
    checkOutput("p_wait", p_wait, (p_rd | p_wr) && !ep_ack);
    checkOutput("d_wait", d_wait, (d_rd | d_wr) && !ed_ack);
    checkOutput("busy", busy, m_active || m_in_ack);
    checkOutput("owner", owner, m_owner);
    checkOutput("mem_read", mem_read, m_active && !m_wr);
    checkOutput("mem_write", mem_write, m_active && m_wr);
    if (m_active) begin
      checkOutput("mem_addr", mem_addr, m_addr);
      checkOutput("mem_wdata", mem_wdata, m_wdata);
    end
  end

  task automatic applyStimulus(
    input logic prd, input logic pwr, input logic [ADDR_W-1:0] pa, input logic [DATA_W-1:0] pw,
    input logic drd, input logic dwr, input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dw,
    input logic mrdy, input logic [DATA_W-1:0] mrd);
    p_rd = prd; p_wr = pwr; p_addr = pa; p_wdata = pw;
    d_rd = drd; d_wr = dwr; d_addr = da; d_wdata = dw;
    mem_ready = mrdy; mem_rdata = mrd;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0, '0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    idleCycle();
    idleCycle();
    reset = 1'b0;
  endtask

  initial begin
    int acks;
    p_rd = 0; p_wr = 0; p_addr = '0; p_wdata = '0;
    d_rd = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_owner", owner, 0);
    checkOutput("rst_mem_read", mem_read, 0);
    checkOutput("rst_p_rdata", p_rdata, 0);

    // Single P read, memory ready on the second BUSY cycle
    applyStimulus(1, 0, 32'h40, '0, 0, 0, '0, '0, 0, '0);
    checkOutput("t1_mem_read_c1", mem_read, 1);
    checkOutput("t1_mem_addr", mem_addr, 32'h40);
    applyStimulus(1, 0, 32'h40, '0, 0, 0, '0, '0, 0, '0);
    checkOutput("t1_mem_read_c2", mem_read, 1);
    applyStimulus(1, 0, 32'h40, '0, 0, 0, '0, '0, 1, 32'hDEADBEEF);
    checkOutput("t1_p_ack", p_ack, 1);
    checkOutput("t1_p_rdata", p_rdata, 32'hDEADBEEF);
    checkOutput("t1_d_ack", d_ack, 0);
    checkOutput("t1_mem_read_ack", mem_read, 0);
    idleCycle();
    checkOutput("t1_p_ack_drop", p_ack, 0);
    checkOutput("t1_p_rdata_hold", p_rdata, 32'hDEADBEEF);

    // Simultaneous requests after reset: P first, D waits
    doReset();
    applyStimulus(0, 1, 32'h10, 32'h1234, 1, 0, 32'h20, '0, 0, '0);
    checkOutput("t2_owner_p", owner, 0);
    checkOutput("t2_mem_write", mem_write, 1);
    checkOutput("t2_d_wait_busy", d_wait, 1);
    applyStimulus(0, 1, 32'h10, 32'h1234, 1, 0, 32'h20, '0, 1, 32'hFFFFFFFF);
    checkOutput("t2_p_ack", p_ack, 1);
    checkOutput("t2_p_rdata_wr", p_rdata, 0);
    checkOutput("t2_d_wait_ack", d_wait, 1);
    applyStimulus(0, 0, '0, '0, 1, 0, 32'h20, '0, 0, '0);
    checkOutput("t2_d_wait_idle", d_wait, 1);
    applyStimulus(0, 0, '0, '0, 1, 0, 32'h20, '0, 0, '0);
    checkOutput("t2_owner_d", owner, 1);
    checkOutput("t2_mem_addr_d", mem_addr, 32'h20);
    applyStimulus(0, 0, '0, '0, 1, 0, 32'h20, '0, 1, 32'hCAFE0020);
    checkOutput("t2_d_ack", d_ack, 1);
    checkOutput("t2_d_rdata", d_rdata, 32'hCAFE0020);
    checkOutput("t2_d_wait_done", d_wait, 0);
    idleCycle();

    // Continuous contention, memory always ready: strict alternation, 3 cycles each
    doReset();
    grant_log.delete();
    acks = 0;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(0, 1, 32'h100, 32'h11110000, 1, 0, 32'h200, '0, 1, 32'h2000 + DATA_W'(i));
      if (p_ack || d_ack) acks++;
    end
    checkOutput("t3_acks", acks, 6);
    checkOutput("t3_grants", grant_log.size(), 6);
    for (int k = 0; k < 6; k++) checkOutput("t3_grant_order", grant_log[k], k % 2);
    checkOutput("t3_d_rdata", d_rdata, 32'h2010);
    idleCycle();

    // D read against a hung memory: abort after TIMEOUT BUSY cycles
    applyStimulus(0, 0, '0, '0, 1, 0, 32'h80, '0, 0, '0);
    for (int j = 0; j < TIMEOUT; j++) begin
      if (j < TIMEOUT - 1) checkOutput("t4_mem_read", mem_read, 1);
      applyStimulus(0, 0, '0, '0, 1, 0, 32'h80, '0, 0, 32'h12345678);
    end
    checkOutput("t4_d_ack", d_ack, 1);
    checkOutput("t4_d_err", d_err, 1);
    checkOutput("t4_d_rdata", d_rdata, 0);
    checkOutput("t4_mem_read_off", mem_read, 0);
    idleCycle();
    checkOutput("t4_d_err_drop", d_err, 0);

    // mem_ready on the very cycle the watchdog would expire
    applyStimulus(1, 0, 32'h90, '0, 0, 0, '0, '0, 0, '0);
    for (int j = 0; j < TIMEOUT - 1; j++)
      applyStimulus(1, 0, 32'h90, '0, 0, 0, '0, '0, 0, '0);
    applyStimulus(1, 0, 32'h90, '0, 0, 0, '0, '0, 1, 32'h5A5A5A5A);
    checkOutput("t5_p_ack", p_ack, 1);
    checkOutput("t5_p_err", p_err, 0);
    checkOutput("t5_p_rdata", p_rdata, 32'h5A5A5A5A);
    idleCycle();

    // Reset in the middle of a P write
    applyStimulus(0, 1, 32'hA0, 32'h77, 0, 0, '0, '0, 0, '0);
    applyStimulus(0, 1, 32'hA0, 32'h77, 0, 0, '0, '0, 0, '0);
    checkOutput("t6_mem_write_pre", mem_write, 1);
    reset = 1'b1;
    #1;
    checkOutput("t6_mem_write_async", mem_write, 0);
    checkOutput("t6_busy_async", busy, 0);
    checkOutput("t6_p_ack_none", p_ack, 0);
    applyStimulus(0, 1, 32'hA0, 32'h77, 1, 1, 32'hB0, 32'h99, 0, '0);
    applyStimulus(0, 1, 32'hA0, 32'h77, 1, 1, 32'hB0, 32'h99, 0, '0);
    reset = 1'b0;
    applyStimulus(0, 1, 32'hA0, 32'h77, 1, 1, 32'hB0, 32'h99, 0, '0);
    checkOutput("t6_owner_p", owner, 0);
    checkOutput("t6_mem_addr", mem_addr, 32'hA0);
    applyStimulus(0, 1, 32'hA0, 32'h77, 1, 1, 32'hB0, 32'h99, 1, 32'h0BADF00D);
    checkOutput("t6_p_ack", p_ack, 1);
    applyStimulus(0, 0, '0, '0, 1, 1, 32'hB0, 32'h99, 0, '0);
    applyStimulus(0, 0, '0, '0, 1, 1, 32'hB0, 32'h99, 0, '0);
    checkOutput("t6_d_wr_dominates", mem_write, 1);
    checkOutput("t6_d_no_read", mem_read, 0);
    checkOutput("t6_d_wdata", mem_wdata, 32'h99);
    applyStimulus(0, 0, '0, '0, 1, 1, 32'hB0, 32'h99, 1, 32'h0BADF00D);
    checkOutput("t6_d_ack", d_ack, 1);
    checkOutput("t6_d_rdata_wr", d_rdata, 0);
    idleCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
